// File: rtl/tff_bank_sync_reset.sv
// tff_bank_sync_reset
//   Bank of WIDTH toggle flip-flops sharing one synchronous active-low reset,
//   a global clock enable and a per-cycle mode: TOGGLE, LOAD, SET or CLEAR.
//   Each channel also emits a one-cycle pulse when it rises. A saturating
//   counter records how many enabled cycles changed q; several bits changing
//   in the same cycle add only one count.
//
//   Optional feature: define TFF_BANK_PARITY_EN to add a registered parity_o
//   output. It always equals ^q_o and is ^RESET_VAL while in reset.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active low. It has priority over every
//              other input.
//   en_i       global enable. When low, q and the counter hold and rise
//              clears.
//   mode_i     00 TOGGLE, 01 LOAD, 10 SET, 11 CLEAR
//   t_i        per-channel toggle/select mask
//   d_i        load data, used in LOAD mode only
//   cnt_clr_i  synchronous clear of the change counter. It beats increment.
//   q_o        flop outputs
//   rise_o     per-bit 0->1 pulse, aligned with the new q_o
//   chg_cnt_o  saturating count of cycles in which q changed
//   parity_o   ^q_o (present only with TFF_BANK_PARITY_EN)

// One channel of the bank. Besides its registered state, it exports its
// next-state value so the top level can detect a change in the same cycle.
module tff_bank_lane #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       t_i,
  input  logic       d_i,
  output logic       q_o,
  output logic       q_nxt_o,
  output logic       rise_o
);
  typedef enum logic [1:0] {
    M_TOGGLE = 2'b00,
    M_LOAD   = 2'b01,
    M_SET    = 2'b10,
    M_CLEAR  = 2'b11
  } mode_e;

  logic q_q, q_d;
  logic rise_q, rise_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      unique case (mode_e'(mode_i))
        M_TOGGLE: q_d = q_q ^ t_i;
        M_LOAD:   q_d = d_i;
        M_SET:    q_d = q_q | t_i;
        M_CLEAR:  q_d = q_q & ~t_i;
        default:  q_d = q_q;
      endcase
    end
    // When en_i is low, q_d equals q_q, so this term is already zero.
    rise_d = q_d & ~q_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= RST_BIT;
      rise_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
    end
  end

  assign q_o     = q_q;
  assign q_nxt_o = q_d;
  assign rise_o  = rise_q;
endmodule

module tff_bank_sync_reset #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o,
`ifdef TFF_BANK_PARITY_EN
  output logic             parity_o,
`endif
  output logic [CNT_W-1:0] chg_cnt_o
);
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    tff_bank_lane #(.RST_BIT(RESET_VAL[i])) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en_i),
      .mode_i  (mode_i),
      .t_i     (t_i[i]),
      .d_i     (d_i[i]),
      .q_o     (q_o[i]),
      .q_nxt_o (q_nxt[i]),
      .rise_o  (rise_o[i])
    );
  end

  // A change is counted once per cycle, however many bits move.
  assign chg = en_i && (q_nxt != q_o);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                cnt_d = '0;
    else if (chg && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign chg_cnt_o = cnt_q;

`ifdef TFF_BANK_PARITY_EN
  // This register is loaded from the lanes' next state on the same edge
  // that updates q, so it tracks ^q with no lag.
  logic parity_q;
  always_ff @(posedge clk) begin
    if (!reset) parity_q <= ^RESET_VAL;
    else        parity_q <= ^q_nxt;
  end
  assign parity_o = parity_q;
`endif
endmodule

// File: tb/tb_tff_bank_sync_reset.sv
module tb_tff_bank_sync_reset;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset, en, cnt_clr;
  logic [1:0]   mode;
  logic [W-1:0] t, d;
  logic [W-1:0] q8, rise8, q2, rise2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;
`ifdef TFF_BANK_PARITY_EN
  logic par8, par2;
`endif

  int checks = 0, failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  tff_bank_sync_reset #(.WIDTH(W), .CNT_W(8), .RESET_VAL(RV)) dut8 (
    .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .t_i(t), .d_i(d),
    .cnt_clr_i(cnt_clr), .q_o(q8), .rise_o(rise8),
`ifdef TFF_BANK_PARITY_EN
    .parity_o(par8),
`endif
    .chg_cnt_o(cnt8));

  tff_bank_sync_reset #(.WIDTH(W), .CNT_W(2), .RESET_VAL(RV)) dut2 (
    .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .t_i(t), .d_i(d),
    .cnt_clr_i(cnt_clr), .q_o(q2), .rise_o(rise2),
`ifdef TFF_BANK_PARITY_EN
    .parity_o(par2),
`endif
    .chg_cnt_o(cnt2));

  // Reference model: outputs as integers, updated from the spec rules each edge
  int m_q, m_rise, m_c8, m_c2;

  always @(posedge clk) begin
    int nq;
    if (!reset) begin
      m_q = RV; m_rise = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      nq = m_q;
      if (en) begin
        if (mode == 2'd0)      nq = m_q ^ t;
        else if (mode == 2'd1) nq = d;
        else if (mode == 2'd2) nq = m_q | t;
        else                   nq = m_q & ~t & 8'hFF;
      end
      m_rise = nq & ~m_q & 8'hFF;
      if (cnt_clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (nq != m_q) begin
        m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
        m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
      end
      m_q = nq;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) if (chk_on) begin
    cmp("q8", int'(q8), m_q);
    cmp("rise8", int'(rise8), m_rise);
    cmp("cnt8", int'(cnt8), m_c8);
    cmp("q2", int'(q2), m_q);
    cmp("rise2", int'(rise2), m_rise);
    cmp("cnt2", int'(cnt2), m_c2);
`ifdef TFF_BANK_PARITY_EN
    cmp("par8", int'(par8), int'(^q8));
    cmp("par2", int'(par2), int'(^m_q[7:0]));
`endif
  end

  task automatic tick(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] tt, input logic [7:0] dd, input logic cc);
    reset = r; en = e; mode = m; t = tt; d = dd; cnt_clr = cc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Literal expectation against the DUT outputs, used to pin the model
  task automatic lit(input string name, input int q, input int r, input int c8, input int c2);
    cmp({name, ".q"}, int'(q8), q);
    cmp({name, ".rise"}, int'(rise8), r);
    cmp({name, ".cnt8"}, int'(cnt8), c8);
    cmp({name, ".cnt2"}, int'(cnt2), c2);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 2'd0; t = '0; d = '0; cnt_clr = 1'b0;
    @(negedge clk);
    // reset for two edges
    tick(0, 1, 0, 8'hFF, 8'h00, 0);
    chk_on = 1'b1;
    tick(0, 1, 0, 8'hFF, 8'h00, 0);
    lit("reset", 'hA5, 0, 0, 0);
    // bring q to 00, then clear the counter on a no-change cycle
    tick(1, 1, 1, 8'h00, 8'h00, 0);  lit("load00", 'h00, 0, 1, 1);
    tick(1, 1, 0, 8'h00, 8'h00, 1);  lit("clr", 'h00, 0, 0, 0);
    // toggle 0F three times
    tick(1, 1, 0, 8'h0F, 8'h00, 0);  lit("tog1", 'h0F, 'h0F, 1, 1);
    tick(1, 1, 0, 8'h0F, 8'h00, 0);  lit("tog2", 'h00, 'h00, 2, 2);
    tick(1, 1, 0, 8'h0F, 8'h00, 0);  lit("tog3", 'h0F, 'h0F, 3, 3);
    // set, clear, no-change load
    tick(1, 1, 2, 8'hF0, 8'h00, 0);  lit("set", 'hFF, 'hF0, 4, 3);
    tick(1, 1, 3, 8'h3C, 8'h00, 0);  lit("clear", 'hC3, 'h00, 5, 3);
    tick(1, 1, 1, 8'hFF, 8'hC3, 0);  lit("ldsame", 'hC3, 'h00, 5, 3);
    // enable low holds everything
    repeat (5) tick(1, 0, 0, 8'hFF, 8'h00, 0);
    lit("hold", 'hC3, 0, 5, 3);
    // saturation of the 2-bit counter
    tick(1, 1, 0, 8'h00, 8'h00, 1);  lit("clr2", 'hC3, 0, 0, 0);
    tick(1, 1, 0, 8'h01, 8'h00, 0);  cmp("sat1", int'(cnt2), 1);
    tick(1, 1, 0, 8'h01, 8'h00, 0);  cmp("sat2", int'(cnt2), 2);
    tick(1, 1, 0, 8'h01, 8'h00, 0);  cmp("sat3", int'(cnt2), 3);
    tick(1, 1, 0, 8'h01, 8'h00, 0);  cmp("sat4", int'(cnt2), 3);
    tick(1, 1, 0, 8'h01, 8'h00, 0);  cmp("sat5", int'(cnt2), 3);
    cmp("cnt8_5", int'(cnt8), 5);
    tick(1, 1, 0, 8'h01, 8'h00, 1);  lit("clrchg", 'hC3, 'h01, 0, 0);
    // reset in the middle of a toggle stream
    tick(1, 1, 0, 8'h5A, 8'h00, 0);
    tick(1, 1, 0, 8'h5A, 8'h00, 0);
    tick(0, 1, 0, 8'h5A, 8'h00, 0);  lit("midrst", 'hA5, 0, 0, 0);
    tick(1, 1, 0, 8'h0F, 8'h00, 0);  lit("postrst", 'hAA, 'h0A, 1, 1);
    // randomized stream; the per-cycle process checks each edge
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) == 0));
    end
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
